// File: rtl/tone_decoder.sv
// Tone decoder: measures the period of a square-wave tone and maps it
// to one of 21 note indices once two consecutive periods agree.
module tone_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic [4:0]  note_idx,
  output logic        note_valid,
  output logic        note_new,
  output logic [17:0] period
);

  typedef enum logic [1:0] {
    WAIT_EDGE,
    MEASURE,
    SEARCH
  } state_t;

  localparam logic [17:0] CNT_MAX = 18'h3FFFF;
  localparam logic [4:0]  LAST    = 5'd20;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  sync;
  logic        edge_det;
  logic [17:0] cnt;
  logic [4:0]  idx;
  logic [4:0]  cand;
  logic [4:0]  ncand;
  logic [1:0]  streak;
  logic [1:0]  nstreak;
  logic        pend;
  logic [17:0] tval;
  logic [18:0] diff;
  logic        hit;
  logic        timeout;
  logic        capture;
  logic        abort;
  logic        srch_end;
  logic        tmo;

  function automatic logic [17:0] note_cycles(input logic [4:0] i);
    case (i)
      5'd0:    note_cycles = 18'd191130;
      5'd1:    note_cycles = 18'd170341;
      5'd2:    note_cycles = 18'd151698;
      5'd3:    note_cycles = 18'd142183;
      5'd4:    note_cycles = 18'd127550;
      5'd5:    note_cycles = 18'd113635;
      5'd6:    note_cycles = 18'd101234;
      5'd7:    note_cycles = 18'd95546;
      5'd8:    note_cycles = 18'd85134;
      5'd9:    note_cycles = 18'd75837;
      5'd10:   note_cycles = 18'd71581;
      5'd11:   note_cycles = 18'd63775;
      5'd12:   note_cycles = 18'd56817;
      5'd13:   note_cycles = 18'd50617;
      5'd14:   note_cycles = 18'd47823;
      5'd15:   note_cycles = 18'd42563;
      5'd16:   note_cycles = 18'd37921;
      5'd17:   note_cycles = 18'd35793;
      5'd18:   note_cycles = 18'd31887;
      5'd19:   note_cycles = 18'd28408;
      5'd20:   note_cycles = 18'd25309;
      default: note_cycles = 18'd0;
    endcase
  endfunction

  assign edge_det = sync[1] & ~sync[2];
  assign timeout  = (cnt == CNT_MAX);
  assign tval     = note_cycles(idx);
  assign diff     = (period >= tval) ? {1'b0, period - tval}
                                     : {1'b0, tval - period};
  // tolerance window is T/64 around each table entry
  assign hit      = (diff <= {7'd0, tval[17:6]});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_EDGE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    abort    = 1'b0;
    srch_end = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      WAIT_EDGE: begin
        if (edge_det) state_nx = MEASURE;
      end
      MEASURE: begin
        if (edge_det) begin
          capture  = 1'b1;
          state_nx = SEARCH;
        end else if (timeout) begin
          tmo      = 1'b1;
          state_nx = WAIT_EDGE;
        end
      end
      SEARCH: begin
        if (edge_det) begin
          capture = 1'b1;
          abort   = 1'b1;
        end else if (timeout) begin
          tmo      = 1'b1;
          state_nx = WAIT_EDGE;
        end else if (hit || idx == LAST) begin
          srch_end = 1'b1;
          state_nx = MEASURE;
        end
      end
      default: state_nx = WAIT_EDGE;
    endcase
  end

  always_comb begin
    ncand   = cand;
    nstreak = streak;
    if (idx == cand) begin
      if (streak != 2'd3) nstreak = streak + 2'd1;
    end else begin
      ncand   = idx;
      nstreak = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync       <= '0;
      cnt        <= '0;
      period     <= '0;
      idx        <= '0;
      cand       <= '0;
      streak     <= '0;
      pend       <= 1'b0;
      note_idx   <= '0;
      note_valid <= 1'b0;
      note_new   <= 1'b0;
    end else begin
      sync     <= {sync[1:0], tone_in};
      note_new <= 1'b0;
      pend     <= 1'b0;
      if (edge_det)     cnt <= 18'd1;
      else if (!timeout) cnt <= cnt + 18'd1;
      if (capture) begin
        period <= cnt;
        idx    <= '0;
      end else if (state == SEARCH) begin
        idx <= idx + 5'd1;
      end
      if (abort || tmo) streak <= '0;
      if (tmo) note_valid <= 1'b0;
      if (srch_end) begin
        if (hit) begin
          cand   <= ncand;
          streak <= nstreak;
          pend   <= (nstreak >= 2'd2) &&
                    (!note_valid || ncand != note_idx);
        end else begin
          streak     <= '0;
          note_valid <= 1'b0;
        end
      end
      // publish one cycle after the search that confirmed the note
      if (pend && !tmo) begin
        note_idx   <= cand;
        note_valid <= 1'b1;
        note_new   <= 1'b1;
      end
    end
  end

endmodule
